// File: rtl/sfp_link_ctrl.sv
// Bring-up and supervision FSM for the 10G SFP MAC/PCS path (dclk domain).
// Sequences the GT reset, qualifies PCS block lock and gates RGMII forwarding.
module sfp_link_ctrl #(
  parameter int unsigned RST_CYCLES    = 1000,
  parameter int unsigned LOCK_TIMEOUT  = 10000000,
  parameter int unsigned STABLE_CYCLES = 100000,
  parameter int unsigned DRAIN_CYCLES  = 2000,
  parameter int unsigned TMR_W         = 24
) (
  input  logic       dclk,
  input  logic       sys_rst_n,
  input  logic       locked,
  input  logic       gt_powergood,
  input  logic       rx_block_lock,
  input  logic [1:0] speed_mode,
  output logic       gt_rst,
  output logic       ctl_tx_send_rfi,
  output logic       ctl_tx_send_idle,
  output logic       fwd_en,
  output logic       link_up,
  output logic [7:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_UP        = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       retry_q, retry_d;
  logic             retry_inc;
  logic             pg_m_q, pg_s, lock_m_q, lock_s;
  logic             gt_rst_q, gt_rst_d;
  logic             rfi_q, rfi_d;
  logic             idle_q, idle_d;
  logic             fwd_q, fwd_d;
  logic             up_q, up_d;

  // State register, synchronisers, timer, retry counter and registered outputs.
  always_ff @(posedge dclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      pg_m_q   <= 1'b0;
      pg_s     <= 1'b0;
      lock_m_q <= 1'b0;
      lock_s   <= 1'b0;
      gt_rst_q <= 1'b1;
      rfi_q    <= 1'b0;
      idle_q   <= 1'b0;
      fwd_q    <= 1'b0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      pg_m_q   <= gt_powergood;
      pg_s     <= pg_m_q;
      lock_m_q <= rx_block_lock;
      lock_s   <= lock_m_q;
      gt_rst_q <= gt_rst_d;
      rfi_q    <= rfi_d;
      idle_q   <= idle_d;
      fwd_q    <= fwd_d;
      up_q     <= up_d;
    end
  end

  // Next state. The clock/power override wins over every timer and lock event.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = 1'b0;
    case (state_q)
      S_IDLE:      if (locked && pg_s) state_d = S_RESET;
      S_RESET:     if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_SETTLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d   = S_RESET;
          retry_inc = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = S_UP;
      end
      S_UP:        if (!lock_s) state_d = S_DRAIN;
      S_DRAIN: begin
        if (timer_q == DRAIN_LAST) begin
          state_d   = S_RESET;
          retry_inc = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && (!locked || !pg_s)) begin
      state_d   = S_IDLE;
      retry_inc = 1'b0;
    end
    if (retry_inc && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
    // IDLE and UP have no terminal count, so the timer holds there.
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (state_q inside {S_RESET, S_WAIT_LOCK, S_SETTLE, S_DRAIN}) timer_d = timer_q + 1'b1;
  end

  // Outputs decoded from the next state so they move together with state_o.
  always_comb begin
    gt_rst_d = 1'b0;
    rfi_d    = 1'b0;
    idle_d   = 1'b0;
    fwd_d    = 1'b0;
    up_d     = 1'b0;
    case (state_d)
      S_IDLE, S_RESET:       gt_rst_d = 1'b1;
      S_WAIT_LOCK, S_SETTLE: rfi_d    = 1'b1;
      S_UP: begin
        up_d  = 1'b1;
        fwd_d = (speed_mode == 2'b10);
      end
      S_DRAIN:               idle_d   = 1'b1;
      default:               gt_rst_d = 1'b1;
    endcase
  end

  assign gt_rst           = gt_rst_q;
  assign ctl_tx_send_rfi  = rfi_q;
  assign ctl_tx_send_idle = idle_q;
  assign fwd_en           = fwd_q;
  assign link_up          = up_q;
  assign retry_cnt        = retry_q;
  assign state_o          = state_q;

endmodule
